// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 scancode receiver.
// Prefix bytes, key field positions and the keyboard control-byte list.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL    = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
    localparam int         PS2_PAUSE_TAIL = 7;
    localparam int         PS2_FRAME_BITS = 11;

    localparam int KEY_STROBE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    // BAT, ACK, resend, echo and the two overrun codes
    localparam logic [5:0][7:0] PS2_CTRL_BYTES = {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    function automatic logic is_ctrl_byte(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (b == PS2_CTRL_BYTES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, agreement filters, bit counter,
// parity/stop check and partial-frame timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5600
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_bad,
    output logic       frame_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-2:0] clk_hist;
    logic [FILTER_LEN-2:0] data_hist;
    logic                  clk_filt;
    logic                  data_filt;
    logic                  clk_filt_q;
    logic [3:0]            bit_cnt;
    logic [7:0]            shift_reg;
    logic                  parity_bit;
    logic [TW-1:0]         timer;
    logic                  sample;
    logic                  last_bit;
    logic                  frame_ok;
    logic                  timeout_hit;

    // The history holds the previous FILTER_LEN-1 samples; together with the
    // current one that is the full agreement window.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            clk_hist   <= '1;
            data_hist  <= '1;
            clk_filt   <= 1'b1;
            data_filt  <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk_in};
            data_sync  <= {data_sync[0], ps2_data_in};
            clk_hist   <= (clk_hist << 1) | (FILTER_LEN-1)'(clk_sync[1]);
            data_hist  <= (data_hist << 1) | (FILTER_LEN-1)'(data_sync[1]);
            if (clk_hist == '1 && clk_sync[1])
                clk_filt <= 1'b1;
            else if (clk_hist == '0 && !clk_sync[1])
                clk_filt <= 1'b0;
            if (data_hist == '1 && data_sync[1])
                data_filt <= 1'b1;
            else if (data_hist == '0 && !data_sync[1])
                data_filt <= 1'b0;
            clk_filt_q <= clk_filt;
        end
    end

    assign sample        = clk_filt_q & ~clk_filt;
    assign last_bit      = (bit_cnt == 4'(PS2_FRAME_BITS - 1));
    assign frame_ok      = (^{shift_reg, parity_bit}) & data_filt;
    assign timeout_hit   = ~sample & (bit_cnt != 4'd0) & (timer == TW'(TIMEOUT_CYCLES - 1));
    assign byte_valid    = sample & last_bit & frame_ok;
    assign frame_bad     = sample & last_bit & ~frame_ok;
    assign frame_timeout = timeout_hit;
    assign byte_data     = shift_reg;

    // A sample edge always takes priority over an expiring timer.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            bit_cnt    <= 4'd0;
            shift_reg  <= 8'd0;
            parity_bit <= 1'b0;
            timer      <= '0;
        end else if (sample) begin
            timer <= '0;
            if (bit_cnt == 4'd0) begin
                if (!data_filt) bit_cnt <= 4'd1;
            end else if (last_bit) begin
                bit_cnt <= 4'd0;
            end else begin
                if (bit_cnt <= 4'd8)
                    shift_reg <= {data_filt, shift_reg[7:1]};
                else
                    parity_bit <= data_filt;
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else if (timeout_hit) begin
            bit_cnt <= 4'd0;
            timer   <= '0;
        end else if (bit_cnt != 4'd0) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver top: prefix/pause decoding of received bytes into
// the toggle-strobe ps2_key event format.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5600
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_bad;
    logic       frame_timeout;
    logic       ext_flag;
    logic       rel_flag;
    logic [2:0] pause_skip;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ps2_clk_in    (ps2_clk_in),
        .ps2_data_in   (ps2_data_in),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .frame_bad     (frame_bad),
        .frame_timeout (frame_timeout)
    );

    // A corrupt frame drops any pending prefix; a timeout leaves it alone.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ps2_key    <= 11'd0;
            frame_err  <= 1'b0;
            ext_flag   <= 1'b0;
            rel_flag   <= 1'b0;
            pause_skip <= 3'd0;
        end else begin
            frame_err <= frame_bad | frame_timeout;
            if (frame_bad) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end else if (byte_valid) begin
                if (pause_skip != 3'd0) begin
                    pause_skip <= pause_skip - 3'd1;
                end else if (byte_data == PS2_PFX_PAUSE) begin
                    pause_skip <= 3'(PS2_PAUSE_TAIL);
                end else if (byte_data == PS2_PFX_EXT) begin
                    ext_flag <= 1'b1;
                end else if (byte_data == PS2_PFX_REL) begin
                    rel_flag <= 1'b1;
                end else if (!ext_flag && !rel_flag && is_ctrl_byte(byte_data)) begin
                    ext_flag <= 1'b0;
                end else if (ext_flag && (byte_data == 8'h12 || byte_data == 8'h59)) begin
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                end else begin
                    ps2_key[7:0]        <= byte_data;
                    ps2_key[KEY_EXT]    <= ext_flag;
                    ps2_key[KEY_PRESSED] <= ~rel_flag;
                    ps2_key[KEY_STROBE] <= ~ps2_key[KEY_STROBE];
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed self-checking bench for ps2_scancode_rx: frames are bit-banged on
// the PS/2 pins and ps2_key / frame_err are checked against hand-computed values.
module tb_ps2_scancode_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 600;
    localparam int HALF           = 40;

    logic        clk_sys;
    logic        reset_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int err_cnt   = 0;
    int evt_cnt   = 0;
    int err_mark;
    int evt_mark;
    logic [10:0] last_key = 11'd0;
    logic        tog      = 1'b0;
    logic [10:0] exp_key;

    ps2_scancode_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk),
        .ps2_data_in (ps2_data),
        .ps2_key     (ps2_key),
        .frame_err   (frame_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (frame_err) err_cnt++;
            if (ps2_key !== last_key) evt_cnt++;
            last_key = ps2_key;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Sends the first nbits bits of an 11-bit frame, optionally with bad parity.
    task automatic applyStimulus(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_sys);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        repeat (2 * HALF) @(negedge clk_sys);
        ps2_data = 1'b1;
    endtask

    task automatic expectEvent(input logic [9:0] v);
        tog     = ~tog;
        exp_key = {tog, v};
    endtask

    initial begin
        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk_sys);
        checkOutput("reset_key", 32'(ps2_key), 32'h000);
        checkOutput("reset_err", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_sys);

        // 1C with the stop bit driven by hand to bound the output latency
        applyStimulus(8'h1C, 1'b0, 10);
        @(negedge clk_sys);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (FILTER_LEN) @(posedge clk_sys);
        #1 checkOutput("stop_hold", 32'(ps2_key), 32'h000);
        repeat (6) @(posedge clk_sys);
        expectEvent(10'h21C);
        #1 checkOutput("first_1C", 32'(ps2_key), 32'(exp_key));
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (2 * HALF) @(negedge clk_sys);
        checkOutput("first_no_err", 32'(err_cnt), 32'd0);

        // release of 1C
        evt_mark = evt_cnt;
        applyStimulus(8'hF0, 1'b0, 11);
        checkOutput("f0_no_event", 32'(evt_cnt - evt_mark), 32'd0);
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent(10'h01C);
        checkOutput("release_1C", 32'(ps2_key), 32'(exp_key));

        // extended release then plain press
        evt_mark = evt_cnt;
        applyStimulus(8'hE0, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h6B, 1'b0, 11);
        expectEvent(10'h16B);
        checkOutput("ext_rel_6B", 32'(ps2_key), 32'(exp_key));
        checkOutput("ext_rel_events", 32'(evt_cnt - evt_mark), 32'd1);
        applyStimulus(8'h6B, 1'b0, 11);
        expectEvent(10'h26B);
        checkOutput("plain_6B", 32'(ps2_key), 32'(exp_key));

        // parity error drops the pending E0
        err_mark = err_cnt;
        applyStimulus(8'hE0, 1'b0, 11);
        applyStimulus(8'h74, 1'b1, 11);
        checkOutput("parity_err", 32'(err_cnt - err_mark), 32'd1);
        checkOutput("parity_hold", 32'(ps2_key), 32'(exp_key));
        applyStimulus(8'h74, 1'b0, 11);
        expectEvent(10'h274);
        checkOutput("after_err_74", 32'(ps2_key), 32'(exp_key));

        // truncated frame then timeout
        err_mark = err_cnt;
        evt_mark = evt_cnt;
        applyStimulus(8'h1C, 1'b0, 5);
        repeat (TIMEOUT_CYCLES + 100) @(negedge clk_sys);
        checkOutput("timeout_err", 32'(err_cnt - err_mark), 32'd1);
        checkOutput("timeout_no_event", 32'(evt_cnt - evt_mark), 32'd0);
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent(10'h21C);
        checkOutput("after_timeout_1C", 32'(ps2_key), 32'(exp_key));

        // Pause sequence yields nothing
        err_mark = err_cnt;
        evt_mark = evt_cnt;
        applyStimulus(8'hE1, 1'b0, 11);
        applyStimulus(8'h14, 1'b0, 11);
        applyStimulus(8'h77, 1'b0, 11);
        applyStimulus(8'hE1, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h14, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 11);
        applyStimulus(8'h77, 1'b0, 11);
        checkOutput("pause_no_event", 32'(evt_cnt - evt_mark), 32'd0);
        checkOutput("pause_no_err", 32'(err_cnt - err_mark), 32'd0);

        // Print Screen with fake shift
        evt_mark = evt_cnt;
        applyStimulus(8'hE0, 1'b0, 11);
        applyStimulus(8'h12, 1'b0, 11);
        applyStimulus(8'hE0, 1'b0, 11);
        applyStimulus(8'h7C, 1'b0, 11);
        expectEvent(10'h37C);
        checkOutput("prtscr_events", 32'(evt_cnt - evt_mark), 32'd1);
        checkOutput("prtscr_key", 32'(ps2_key), 32'(exp_key));

        // short clock glitch with data low must not start a frame
        err_mark = err_cnt;
        @(negedge clk_sys);
        ps2_data = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        applyStimulus(8'h1C, 1'b0, 11);
        expectEvent(10'h21C);
        checkOutput("glitch_key", 32'(ps2_key), 32'(exp_key));
        checkOutput("glitch_no_err", 32'(err_cnt - err_mark), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
